// File: rtl/ht_pkg.sv
// ht_pkg: PSI46 stream constants, FSM state type and payload builder shared by the generator.
package ht_pkg;
   localparam logic [8:0] LEADER = 9'b011111111;
   localparam logic [2:0] ID_TBMH = 3'b100;
   localparam logic [2:0] ID_TRL_OLD = 3'b111;
   localparam logic [2:0] ID_TRL_NEW = 3'b110;
   localparam int LEN_TBM = 32;
   localparam int LEN_ROC = 12;
   localparam int LEN_HIT = 24;
   typedef enum logic [2:0] {S_IDLE, S_TBMH, S_ROCH, S_HIT, S_TRL, S_GAP} state_e;
   // zero after every nibble so no run of eight ones can mimic a leader
   function automatic logic [19:0] payload(input logic [7:0] a, input logic [7:0] b);
      return {a[7:4], 1'b0, a[3:0], 1'b0, b[7:4], 1'b0, b[3:0], 1'b0};
   endfunction
endpackage

// File: rtl/header_trailer_gen_if.sv
// header_trailer_gen_if: hit token stream from the hit source into the generator.
interface header_trailer_gen_if;
   logic hit_valid;
   logic hit_eor;
   logic hit_ready;
   logic [23:0] hit_data;
   modport master (output hit_valid, hit_eor, hit_data, input hit_ready);
   modport slave (input hit_valid, hit_eor, hit_data, output hit_ready);
endinterface

// File: rtl/ht_serializer.sv
// ht_serializer: 32-bit MSB-first shift register with bit-length load and last/penultimate flags.
module ht_serializer #(
   parameter int CW = 6
) (
   input  logic CLK,
   input  logic reset,
   input  logic load,
   input  logic [CW-1:0] len,
   input  logic [31:0] word,
   output logic sdat,
   output logic last,
   output logic penult
);
   logic [31:0] sr_q, sr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      sr_d = load ? word : {sr_q[30:0], 1'b0};
      cnt_d = load ? len - 1'b1 : (cnt_q == '0 ? '0 : cnt_q - 1'b1);
   end
   always_ff @(posedge CLK)
      if (reset) begin
         sr_q <= '0;
         cnt_q <= '0;
      end else begin
         sr_q <= sr_d;
         cnt_q <= cnt_d;
      end
   assign sdat = sr_q[31];
   assign last = cnt_q == '0;
   assign penult = cnt_q == CW'(1);
endmodule

// File: rtl/header_trailer_gen.sv
// header_trailer_gen: serial PSI46 event generator emitting TBM header, ROC headers with hits
// and TBM trailer on one line, followed by an idle gap.
module header_trailer_gen import ht_pkg::*; #(
   parameter int NROC = 8,
   parameter int GAPLEN = 8
) (
   input  logic CLK,
   input  logic reset,
   input  logic trigger,
   input  logic [7:0] evnum,
   input  logic [7:0] tbm_stat,
   input  logic [1:0] roc_sd,
   input  logic Trailer_OLD_NEW_0_1,
   header_trailer_gen_if.slave hs,
   output logic sdat,
   output logic busy,
   output logic done,
   output logic underflow,
   output logic trig_missed
);
   localparam int CW = $clog2((GAPLEN > LEN_TBM ? GAPLEN : LEN_TBM) + 1);
   localparam int RW = NROC > 1 ? $clog2(NROC) : 1;
   state_e state_q, state_d;
   logic [RW-1:0] roc_q, roc_d;
   logic [7:0] stat_q, stat_d;
   logic [1:0] sd_q, sd_d;
   logic trl_q, trl_d;
   logic busy_q, busy_d, done_q, done_d, uf_q, uf_d, miss_q, miss_d, rdy_q, rdy_d;
   logic ld, last, penult, is_hit;
   logic [CW-1:0] len;
   logic [31:0] word;
   ht_serializer #(.CW(CW)) u_ser (
      .CLK(CLK), .reset(reset), .load(ld), .len(len), .word(word),
      .sdat(sdat), .last(last), .penult(penult)
   );
   always_comb begin
      state_d = state_q;
      roc_d = roc_q;
      stat_d = stat_q;
      sd_d = sd_q;
      trl_d = trl_q;
      uf_d = uf_q;
      ld = 1'b0;
      len = CW'(LEN_ROC);
      word = {LEADER, 1'b0, sd_q, 20'h0};
      is_hit = hs.hit_valid && !hs.hit_eor;
      case (state_q)
         S_IDLE: if (trigger) begin
            state_d = S_TBMH;
            ld = 1'b1;
            len = CW'(LEN_TBM);
            word = {LEADER, ID_TBMH, payload(evnum, 8'h00)};
            stat_d = tbm_stat;
            sd_d = roc_sd;
            trl_d = Trailer_OLD_NEW_0_1;
            roc_d = '0;
         end
         S_TBMH: if (last) begin
            state_d = S_ROCH;
            ld = 1'b1;
         end
         S_ROCH, S_HIT: if (last) begin
            ld = 1'b1;
            if (is_hit) begin
               state_d = S_HIT;
               len = CW'(LEN_HIT);
               word = {hs.hit_data & ~24'h001000, 8'h00};
            end else begin
               // a missing token is taken as end-of-ROC so the stream never stalls
               uf_d = uf_q | !hs.hit_valid;
               if (roc_q == RW'(NROC - 1)) begin
                  state_d = S_TRL;
                  len = CW'(LEN_TBM);
                  word = {LEADER, trl_q ? ID_TRL_NEW : ID_TRL_OLD, payload(stat_q, 8'h00)};
               end else begin
                  state_d = S_ROCH;
                  roc_d = roc_q + 1'b1;
               end
            end
         end
         S_TRL: if (last) begin
            state_d = S_GAP;
            ld = 1'b1;
            len = CW'(GAPLEN);
            word = '0;
         end
         S_GAP: if (last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = state_d != S_IDLE;
      done_d = state_q == S_TRL && penult;
      rdy_d = (state_q == S_ROCH || state_q == S_HIT) && penult;
      miss_d = trigger && state_q != S_IDLE;
   end
   always_ff @(posedge CLK)
      if (reset) begin
         state_q <= S_IDLE;
         roc_q <= '0;
         stat_q <= '0;
         sd_q <= '0;
         trl_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         uf_q <= 1'b0;
         miss_q <= 1'b0;
         rdy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         roc_q <= roc_d;
         stat_q <= stat_d;
         sd_q <= sd_d;
         trl_q <= trl_d;
         busy_q <= busy_d;
         done_q <= done_d;
         uf_q <= uf_d;
         miss_q <= miss_d;
         rdy_q <= rdy_d;
      end
   assign busy = busy_q;
   assign done = done_q;
   assign underflow = uf_q;
   assign trig_missed = miss_q;
   assign hs.hit_ready = rdy_q;
endmodule

// File: tb/tb_header_trailer_gen.sv
// tb_header_trailer_gen: randomized scoreboard bench; events are predicted bit by bit from the
// stream format rules and compared against what the monitor captures while busy is high.
module tb_header_trailer_gen;
   localparam int NROC = 2;
   localparam int GAPLEN = 8;
   typedef struct { int kind; logic [23:0] d; } tok_t;   // kind: 0 hit, 1 end-of-ROC, 2 missing
   logic CLK = 0, reset = 1, trigger = 0, sel = 0;
   logic [7:0] evnum = 0, tbm_stat = 0;
   logic [1:0] roc_sd = 0;
   logic sdat, busy, done, underflow, trig_missed;
   header_trailer_gen_if hs();
   header_trailer_gen #(.NROC(NROC), .GAPLEN(GAPLEN)) dut (
      .CLK(CLK), .reset(reset), .trigger(trigger), .evnum(evnum), .tbm_stat(tbm_stat),
      .roc_sd(roc_sd), .Trailer_OLD_NEW_0_1(sel), .hs(hs), .sdat(sdat), .busy(busy),
      .done(done), .underflow(underflow), .trig_missed(trig_missed)
   );
   always #5 CLK = ~CLK;
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;
   logic [511:0] sb_vec[$];
   int sb_len[$], sb_cut[$], sb_start[$];
   logic sb_uf[$];
   tok_t plan[$], evtoks[$];
   int checks = 0, fails = 0, exp_miss = 0, obs_miss = 0, nseen = 0;
   logic uf_model = 0, started = 0, in_ev = 0;
   logic [511:0] mv, obs;
   int ml, olen, dcount, didx;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic app(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         mv = {mv[510:0], v[i]};
         ml++;
      end
   endtask

   task automatic app_payload(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] ab;
      ab = {a, b};
      for (int n = 3; n >= 0; n--) begin
         app(32'(ab[n*4 +: 4]), 4);
         app(32'd0, 1);
      end
   endtask

   // whole event from the format rules: header, per-ROC header plus hits, trailer
   task automatic build_model(input logic [7:0] ev, input logic [7:0] st, input logic [1:0] sd,
                              input logic s, output logic miss_tok);
      int k;
      logic fin;
      k = 0;
      mv = '0;
      ml = 0;
      miss_tok = 0;
      app(32'h0FF, 9); app(32'h4, 3); app_payload(ev, 8'h00);
      for (int r = 0; r < NROC; r++) begin
         app(32'h0FF, 9); app(32'd0, 1); app(32'(sd), 2);
         fin = 0;
         while (!fin && k < evtoks.size()) begin
            if (evtoks[k].kind == 0) begin
               app(32'(evtoks[k].d[23:13]), 11); app(32'd0, 1); app(32'(evtoks[k].d[11:0]), 12);
            end else begin
               fin = 1;
               if (evtoks[k].kind == 2) miss_tok = 1;
            end
            k++;
         end
      end
      app(32'h0FF, 9); app(s ? 32'h6 : 32'h7, 3); app_payload(st, 8'h00);
   endtask

   task automatic tok(input int kind, input logic [23:0] d);
      tok_t t;
      t.kind = kind;
      t.d = d;
      evtoks.push_back(t);
   endtask

   task automatic rand_plan(input int none_pct);
      evtoks.delete();
      for (int r = 0; r < NROC; r++) begin
         repeat ($urandom_range(0, 2)) tok(0, 24'($urandom));
         tok(($urandom_range(0, 99) < none_pct) ? 2 : 1, 24'($urandom));
      end
   endtask

   // called at a negedge with the DUT idle; returns at the negedge where busy should be low again
   task automatic run_event(input logic [7:0] ev, input logic [7:0] st, input logic [1:0] sd,
                            input logic s, input int misses, input int abort_at);
      logic mt;
      int tot;
      build_model(ev, st, sd, s, mt);
      foreach (evtoks[i]) plan.push_back(evtoks[i]);
      sb_vec.push_back(mv);
      sb_len.push_back(ml);
      sb_start.push_back(cyc + 1);
      if (abort_at >= 0) begin
         sb_cut.push_back(abort_at + 1);
         sb_uf.push_back(1'b0);
         uf_model = 0;
      end else begin
         uf_model = uf_model | mt;
         sb_cut.push_back(ml);
         sb_uf.push_back(uf_model);
      end
      evnum = ev; tbm_stat = st; roc_sd = sd; sel = s; trigger = 1;
      @(negedge CLK);
      trigger = 0;
      evnum = 8'($urandom); tbm_stat = 8'($urandom); roc_sd = 2'($urandom); sel = 1'($urandom);
      if (abort_at >= 0) begin
         repeat (abort_at) @(negedge CLK);
         reset = 1;
         @(negedge CLK);
         reset = 0;
         plan.delete();
      end else begin
         tot = ml + GAPLEN;
         for (int i = 1; i < tot; i++) begin
            @(negedge CLK);
            trigger = ((tot - 1 - i) % 3 == 0) && ((tot - 1 - i) / 3 < misses);
         end
         @(negedge CLK);
         trigger = 0;
         exp_miss += misses;
      end
   endtask

   task automatic finish_event();
      logic [511:0] ev, e;
      int len, cut, eo, diff;
      logic euf;
      if (sb_len.size() == 0) begin
         chk("unexpected_event_len", 64'(olen), 64'd0);
         return;
      end
      ev = sb_vec.pop_front(); len = sb_len.pop_front(); cut = sb_cut.pop_front();
      euf = sb_uf.pop_front(); void'(sb_start.pop_front());
      if (cut == len) begin
         e = ev << GAPLEN;
         eo = len + GAPLEN;
      end else begin
         e = ev >> (len - cut);
         eo = cut;
      end
      chk("busy_length", 64'(olen), 64'(eo));
      diff = -1;
      for (int k = 0; k < olen && k < eo; k++)
         if (diff < 0 && obs[olen-1-k] !== e[eo-1-k]) diff = k;
      chk("first_bit_mismatch", 64'(diff), 64'(-1));
      chk("done_pulses", 64'(dcount), (cut == len) ? 64'd1 : 64'd0);
      if (cut == len) chk("done_position", 64'(didx), 64'(len - 1));
      chk("underflow", 64'(underflow), 64'(euf));
      if (nseen == 0 && olen >= 22) chk("first_22_bits", 64'(obs[olen-1 -: 22]), 64'(22'b0111111111000101010100));
      nseen++;
   endtask

   always @(negedge CLK) begin
      if (started) begin
         if (trig_missed === 1'b1) obs_miss++;
         if (busy === 1'b1) begin
            if (!in_ev) begin
               in_ev = 1; olen = 0; obs = '0; dcount = 0; didx = -1;
               if (sb_start.size() > 0) chk("start_cycle", 64'(cyc), 64'(sb_start[0]));
            end
            obs = {obs[510:0], sdat};
            olen++;
            if (done === 1'b1) begin
               dcount++;
               didx = olen - 1;
            end
         end else begin
            if (in_ev) finish_event();
            in_ev = 0;
            chk("idle_sdat_done_ready", 64'({sdat, done, hs.hit_ready}), 64'd0);
         end
      end
   end

   initial begin
      tok_t t;
      hs.hit_valid = 0; hs.hit_eor = 0; hs.hit_data = '0;
      forever begin
         @(posedge CLK);
         #1;
         if (hs.hit_ready === 1'b1) begin
            if (plan.size() > 0) t = plan.pop_front();
            else begin t.kind = 2; t.d = '0; end
            hs.hit_valid = (t.kind != 2);
            hs.hit_eor = (t.kind == 1) || (t.kind == 2 && $urandom_range(0, 1) == 1);
            hs.hit_data = (t.kind == 0) ? t.d : 24'($urandom);
         end else begin
            hs.hit_valid = 1'($urandom); hs.hit_eor = 1'($urandom); hs.hit_data = 24'($urandom);
         end
      end
   end

   always @(posedge CLK)
      if (cyc > 60000) begin
         $display("FAIL watchdog: cycle %0d exceeded budget 60000", cyc);
         $fatal(1, "timeout");
      end

   initial begin
      repeat (3) @(negedge CLK);
      chk("reset_outputs", 64'({sdat, busy, done, hs.hit_ready, underflow, trig_missed}), 64'd0);
      reset = 0;
      started = 1;
      @(negedge CLK);
      evtoks.delete(); tok(1, 0); tok(1, 0);
      run_event(8'h5A, 8'h3C, 2'b00, 1'b0, 0, -1);
      evtoks.delete(); tok(0, 24'h123456); tok(1, 0); tok(1, 0);
      run_event(8'h01, 8'h80, 2'b10, 1'b0, 0, -1);
      evtoks.delete(); tok(1, 0); tok(1, 0);
      run_event(8'hFF, 8'hFF, 2'b11, 1'b1, 0, -1);
      evtoks.delete(); tok(2, 0); tok(2, 0);
      run_event(8'h33, 8'h44, 2'b01, 1'b0, 0, -1);
      rand_plan(0);
      run_event(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 3, -1);
      rand_plan(0);
      run_event(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 0, 40);
      rand_plan(0);
      run_event(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 0, -1);
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge CLK);
         rand_plan(10);
         run_event(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 2), -1);
      end
      repeat (5) @(negedge CLK);
      chk("pending_events", 64'(sb_len.size()), 64'd0);
      chk("trig_missed_pulses", 64'(obs_miss), 64'(exp_miss));
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
